// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: streams one pixel per clock over a latched rectangle,
// solid or checkerboard, clipping anything that falls off the visible screen.
module rect_fill_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     xOrigin,
    input  logic [Y_W-1:0]     yOrigin,
    input  logic [X_W-1:0]     rectW,
    input  logic [Y_W-1:0]     rectH,
    input  logic               mode,
    input  logic [COLOR_W-1:0] colorA,
    input  logic [COLOR_W-1:0] colorB,
    output logic [X_W-1:0]     xOut,
    output logic [Y_W-1:0]     yOut,
    output logic [COLOR_W-1:0] colorOut,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [X_W:0]   LP_SCREEN_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   LP_SCREEN_H = (Y_W+1)'(SCREEN_H);
    localparam logic [X_W-1:0] LP_X_ONE    = {{(X_W-1){1'b0}}, 1'b1};
    localparam logic [Y_W-1:0] LP_Y_ONE    = {{(Y_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;

    logic [X_W-1:0]       r_x0;
    logic [Y_W-1:0]       r_y0;
    logic [X_W-1:0]       r_w;
    logic [Y_W-1:0]       r_h;
    logic                 r_mode;
    logic [COLOR_W-1:0]   r_ca;
    logic [COLOR_W-1:0]   r_cb;

    logic [X_W-1:0]       r_cx;
    logic [Y_W-1:0]       r_cy;
    logic [X_W-1:0]       r_xout;
    logic [Y_W-1:0]       r_yout;
    logic [COLOR_W-1:0]   r_col;
    logic                 r_plot;
    logic                 r_busy;
    logic                 r_done;

    logic [X_W-1:0]       w_cx_nxt;
    logic [Y_W-1:0]       w_cy_nxt;
    logic [X_W-1:0]       w_xout_nxt;
    logic [Y_W-1:0]       w_yout_nxt;
    logic [COLOR_W-1:0]   w_col_nxt;
    logic                 w_plot_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_latch;

    logic [X_W:0]         w_xsum;
    logic [Y_W:0]         w_ysum;
    logic                 w_cx_last;
    logic                 w_cy_last;

    function automatic logic [COLOR_W-1:0] pix_color(
        input logic               m,
        input logic               odd,
        input logic [COLOR_W-1:0] ca,
        input logic [COLOR_W-1:0] cb
    );
        return (m && odd) ? cb : ca;
    endfunction

    // Sums are one bit wider than the coordinates so overflow past the screen
    // edge is still seen as off-screen instead of wrapping back on.
    function automatic logic on_screen(
        input logic [X_W:0] xs,
        input logic [Y_W:0] ys
    );
        return (xs < LP_SCREEN_W) && (ys < LP_SCREEN_H);
    endfunction

    assign w_xsum    = {1'b0, r_x0} + {1'b0, r_cx};
    assign w_ysum    = {1'b0, r_y0} + {1'b0, r_cy};
    assign w_cx_last = (r_cx == (r_w - LP_X_ONE));
    assign w_cy_last = (r_cy == (r_h - LP_Y_ONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
            r_xout  <= '0;
            r_yout  <= '0;
            r_col   <= '0;
            r_plot  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cx    <= w_cx_nxt;
            r_cy    <= w_cy_nxt;
            r_xout  <= w_xout_nxt;
            r_yout  <= w_yout_nxt;
            r_col   <= w_col_nxt;
            r_plot  <= w_plot_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Rectangle parameters are only consumed while busy, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_x0   <= xOrigin;
            r_y0   <= yOrigin;
            r_w    <= rectW;
            r_h    <= rectH;
            r_mode <= mode;
            r_ca   <= colorA;
            r_cb   <= colorB;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cx_nxt    = r_cx;
        w_cy_nxt    = r_cy;
        w_xout_nxt  = r_xout;
        w_yout_nxt  = r_yout;
        w_col_nxt   = r_col;
        w_plot_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch    = 1'b1;
                    w_cx_nxt   = '0;
                    w_cy_nxt   = '0;
                    w_busy_nxt = 1'b1;
                    if ((rectW == '0) || (rectH == '0))
                        w_state_nxt = S_DONE;
                    else
                        w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                w_busy_nxt = 1'b1;
                w_xout_nxt = w_xsum[X_W-1:0];
                w_yout_nxt = w_ysum[Y_W-1:0];
                w_col_nxt  = pix_color(r_mode, r_cx[0] ^ r_cy[0], r_ca, r_cb);
                w_plot_nxt = on_screen(w_xsum, w_ysum);
                if (!w_cx_last) begin
                    w_cx_nxt = r_cx + LP_X_ONE;
                end else begin
                    w_cx_nxt = '0;
                    if (!w_cy_last)
                        w_cy_nxt = r_cy + LP_Y_ONE;
                    else
                        w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_busy_nxt  = 1'b1;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign xOut     = r_xout;
    assign yOut     = r_yout;
    assign colorOut = r_col;
    assign plot     = r_plot;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: directed scenarios plus randomized fills compared
// against a loop-based model of which pixels a rectangle should plot.
module tb_rect_fill_engine;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;
    localparam int SW  = 160;
    localparam int SH  = 120;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [X_W-1:0] xOrigin;
    logic [Y_W-1:0] yOrigin;
    logic [X_W-1:0] rectW;
    logic [Y_W-1:0] rectH;
    logic           mode;
    logic [C_W-1:0] colorA;
    logic [C_W-1:0] colorB;
    logic [X_W-1:0] xOut;
    logic [Y_W-1:0] yOut;
    logic [C_W-1:0] colorOut;
    logic           plot;
    logic           busy;
    logic           done;

    rect_fill_engine #(
        .SCREEN_W(SW), .SCREEN_H(SH), .X_W(X_W), .Y_W(Y_W), .COLOR_W(C_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .xOrigin(xOrigin), .yOrigin(yOrigin), .rectW(rectW), .rectH(rectH),
        .mode(mode), .colorA(colorA), .colorB(colorB),
        .xOut(xOut), .yOut(yOut), .colorOut(colorOut),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t cap_q[$];
    pix_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   done_k;
    int   busy_bad;
    int   last_x;
    int   last_y;

    // Model: every pixel of the rectangle in row-major order, keeping only the
    // on-screen ones; checker parity is the parity of the in-rectangle offset.
    task automatic build_exp(input int x0, input int y0, input int w, input int h,
                             input int m, input int ca, input int cb);
        pix_t p;
        exp_q.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                p.x = x0 + x;
                p.y = y0 + y;
                p.c = (m != 0 && ((x + y) % 2) == 1) ? cb : ca;
                if (p.x < SW && p.y < SH) exp_q.push_back(p);
            end
        end
    endtask

    function automatic int first_diff();
        if (cap_q.size() != exp_q.size()) return -2;
        foreach (cap_q[i]) begin
            if (cap_q[i].x != exp_q[i].x || cap_q[i].y != exp_q[i].y ||
                cap_q[i].c != exp_q[i].c) return i;
        end
        return -1;
    endfunction

    // Issue one start and record plotted pixels until done (or the limit).
    task automatic do_fill(input int x0, input int y0, input int w, input int h,
                           input int m, input int ca, input int cb,
                           input bit scramble, input int limit);
        pix_t p;
        cap_q.delete();
        done_k   = -1;
        busy_bad = 0;
        @(negedge clk);
        xOrigin = x0[X_W-1:0];
        yOrigin = y0[Y_W-1:0];
        rectW   = w[X_W-1:0];
        rectH   = h[Y_W-1:0];
        mode    = m[0];
        colorA  = ca[C_W-1:0];
        colorB  = cb[C_W-1:0];
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (busy !== 1'b1 || plot !== 1'b0 || done !== 1'b0) busy_bad++;
        for (int k = 1; k <= limit; k++) begin
            if (scramble) begin
                xOrigin = 8'($urandom);
                yOrigin = 7'($urandom);
                rectW   = 8'($urandom);
                rectH   = 7'($urandom);
                mode    = 1'($urandom);
                colorA  = 3'($urandom);
                colorB  = 3'($urandom);
                start   = 1'($urandom);
            end
            @(negedge clk);
            if (plot === 1'b1) begin
                p.x = int'(xOut);
                p.y = int'(yOut);
                p.c = int'(colorOut);
                cap_q.push_back(p);
            end
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                done_k = k;
                last_x = int'(xOut);
                last_y = int'(yOut);
                start  = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        xOrigin = '0; yOrigin = '0; rectW = '0; rectH = '0;
        mode = 1'b0; colorA = '0; colorB = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({xOut, yOut, colorOut, plot, busy, done} !== '0)
            $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b, required all 0",
                     xOut, yOut, colorOut, plot, busy, done);
        else passes++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({plot, busy, done} !== 3'b000)
            $display("FAIL idle_after_reset: got plot/busy/done=%b%b%b, required 000", plot, busy, done);
        else passes++;
    endtask

    task automatic test_full_clear();
        int d;
        do_fill(0, 0, 160, 120, 0, 0, 0, 1'b0, 20000);
        build_exp(0, 0, 160, 120, 0, 0, 0);
        checks++;
        if (cap_q.size() != 19200)
            $display("FAIL clear_plot_count: got %0d, required 19200", cap_q.size());
        else passes++;
        d = first_diff();
        checks++;
        if (d != -1) $display("FAIL clear_pixels: first difference at %0d, required none", d);
        else passes++;
        checks++;
        if (done_k != 19201) $display("FAIL clear_done_latency: got %0d, required 19201", done_k);
        else passes++;
        checks++;
        if (last_x != 159 || last_y != 119)
            $display("FAIL clear_last_pixel: got (%0d,%0d), required (159,119)", last_x, last_y);
        else passes++;
        checks++;
        if (busy_bad != 0) $display("FAIL clear_busy: got %0d bad cycles, required 0", busy_bad);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL clear_after_done: got busy=%b done=%b, required 0 0", busy, done);
        else passes++;
    endtask

    task automatic test_small_rect();
        int d;
        do_fill(10, 5, 3, 2, 0, 5, 0, 1'b0, 100);
        build_exp(10, 5, 3, 2, 0, 5, 0);
        d = first_diff();
        checks++;
        if (d != -1 || cap_q.size() != 6)
            $display("FAIL small_pixels: first difference %0d count %0d, required none and 6", d, cap_q.size());
        else passes++;
        checks++;
        if (done_k != 7) $display("FAIL small_done_latency: got %0d, required 7", done_k);
        else passes++;
    endtask

    task automatic test_clipping();
        int d;
        do_fill(158, 118, 4, 4, 0, 2, 0, 1'b0, 100);
        build_exp(158, 118, 4, 4, 0, 2, 0);
        checks++;
        if (cap_q.size() != 4) $display("FAIL clip_count: got %0d, required 4", cap_q.size());
        else passes++;
        d = first_diff();
        checks++;
        if (d != -1) $display("FAIL clip_pixels: first difference at %0d, required none", d);
        else passes++;
        checks++;
        if (done_k != 17) $display("FAIL clip_done_latency: got %0d, required 17", done_k);
        else passes++;
    endtask

    task automatic test_checker();
        int want_c[4] = '{1, 6, 6, 1};
        int bad;
        do_fill(0, 0, 2, 2, 1, 1, 6, 1'b0, 100);
        bad = (cap_q.size() == 4) ? 0 : 1;
        if (bad == 0)
            for (int i = 0; i < 4; i++) if (cap_q[i].c != want_c[i]) bad++;
        checks++;
        if (bad != 0)
            $display("FAIL checker_colors: got %0d wrong (count %0d), required colours 1,6,6,1",
                     bad, cap_q.size());
        else passes++;
    endtask

    task automatic test_empty();
        do_fill(5, 5, 0, 7, 0, 3, 0, 1'b0, 50);
        checks++;
        if (done_k != 1 || cap_q.size() != 0)
            $display("FAIL empty_w: got done at %0d with %0d plots, required 1 and 0", done_k, cap_q.size());
        else passes++;
        do_fill(5, 5, 9, 0, 0, 3, 0, 1'b0, 50);
        checks++;
        if (done_k != 1 || cap_q.size() != 0)
            $display("FAIL empty_h: got done at %0d with %0d plots, required 1 and 0", done_k, cap_q.size());
        else passes++;
    endtask

    task automatic test_ignored_start();
        int d;
        int extra = 0;
        do_fill(30, 40, 4, 1, 0, 3, 0, 1'b1, 100);
        build_exp(30, 40, 4, 1, 0, 3, 0);
        d = first_diff();
        checks++;
        if (d != -1 || done_k != 5)
            $display("FAIL ignored_start: first difference %0d done at %0d, required none and 5", d, done_k);
        else passes++;
        repeat (3) begin
            @(negedge clk);
            if (plot !== 1'b0 || done !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) $display("FAIL ignored_start_queued: got %0d active cycles, required 0", extra);
        else passes++;
    endtask

    task automatic test_reset_midfill();
        int d;
        @(negedge clk);
        xOrigin = 8'd20; yOrigin = 7'd30; rectW = 8'd10; rectH = 7'd10;
        mode = 1'b0; colorA = 3'd4; colorB = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (plot !== 1'b1 || xOut !== 8'd24 || yOut !== 7'd30)
            $display("FAIL midfill_fifth_pixel: got plot=%b (%0d,%0d), required 1 (24,30)", plot, xOut, yOut);
        else passes++;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({xOut, yOut, colorOut, plot, busy, done} !== '0)
            $display("FAIL midfill_reset: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b, required all 0",
                     xOut, yOut, colorOut, plot, busy, done);
        else passes++;
        reset = 1'b0;
        do_fill(20, 30, 10, 10, 0, 4, 0, 1'b0, 300);
        build_exp(20, 30, 10, 10, 0, 4, 0);
        d = first_diff();
        checks++;
        if (d != -1 || done_k != 101)
            $display("FAIL midfill_restart: first difference %0d done at %0d, required none and 101", d, done_k);
        else passes++;
    endtask

    task automatic test_random();
        int x0, y0, w, h, m, ca, cb, d, want_k;
        bit scr;
        for (int t = 0; t < 25; t++) begin
            x0  = int'($urandom_range(0, 255));
            y0  = int'($urandom_range(0, 127));
            w   = int'($urandom_range(0, 20));
            h   = int'($urandom_range(0, 12));
            m   = int'($urandom_range(0, 1));
            ca  = int'($urandom_range(0, 7));
            cb  = int'($urandom_range(0, 7));
            scr = 1'($urandom);
            do_fill(x0, y0, w, h, m, ca, cb, scr, 400);
            build_exp(x0, y0, w, h, m, ca, cb);
            want_k = (w == 0 || h == 0) ? 1 : w * h + 1;
            d = first_diff();
            checks++;
            if (d != -1 || done_k != want_k || busy_bad != 0)
                $display("FAIL random_%0d (%0d,%0d %0dx%0d m%0d): diff %0d done %0d busy_bad %0d, required -1 %0d 0",
                         t, x0, y0, w, h, m, d, done_k, busy_bad, want_k);
            else passes++;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_small_rect();
        test_clipping();
        test_checker();
        test_empty();
        test_ignored_start();
        test_reset_midfill();
        test_random();
        test_full_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
